// File: rtl/alloc_dispatcher_pkg.sv
// Shared types and constants for the allocation dispatcher: id/size-class
// widths, size-class codes, dispatcher FSM state encoding and the size
// classification helpers used at push time.
package alloc_dispatcher_pkg;

  localparam int REQ_ID_WIDTH        = 8;
  localparam int REQ_SIZE_TYPE_WIDTH = 2;
  localparam int unsigned REQ_MAX_BYTES = 4096;

  localparam logic [REQ_SIZE_TYPE_WIDTH-1:0] REQ_512 = 2'd0;
  localparam logic [REQ_SIZE_TYPE_WIDTH-1:0] REQ_1K  = 2'd1;
  localparam logic [REQ_SIZE_TYPE_WIDTH-1:0] REQ_2K  = 2'd2;
  localparam logic [REQ_SIZE_TYPE_WIDTH-1:0] REQ_4K  = 2'd3;

  typedef enum logic [1:0] {
    DSP_IDLE    = 2'd0,
    DSP_ISSUE   = 2'd1,
    DSP_CHECK   = 2'd2,
    DSP_BACKOFF = 2'd3
  } dsp_state_t;

  // Round a legal byte count up to its size class.
  function automatic logic [REQ_SIZE_TYPE_WIDTH-1:0] size_to_class(input int unsigned bytes);
    if (bytes <= 512)       return REQ_512;
    else if (bytes <= 1024) return REQ_1K;
    else if (bytes <= 2048) return REQ_2K;
    else                    return REQ_4K;
  endfunction

  // Zero-byte and oversize requests cannot be served by any class.
  function automatic logic size_is_legal(input int unsigned bytes);
    return (bytes != 0) && (bytes <= REQ_MAX_BYTES);
  endfunction

endpackage

// File: rtl/alloc_dispatcher_if.sv
// Bus bundle around the dispatcher. Handshake rule for the request side:
// a request transfers on a rising clock edge where req_valid and req_ready
// are both high; req_ready depends only on queue occupancy, never on
// req_valid. The issue side (alloc_valid_dsp_out) is a one-cycle pulse
// with no back-pressure; find_table answers through fdt_blocked.
interface alloc_dispatcher_if
  import alloc_dispatcher_pkg::*;
#(
  parameter int SIZE_WIDTH = 13
);
  logic                           req_valid;
  logic                           req_ready;
  logic [REQ_ID_WIDTH-1:0]        req_id;
  logic [SIZE_WIDTH-1:0]          req_size;
  logic                           alloc_valid_dsp_out;
  logic [REQ_ID_WIDTH-1:0]        alloc_id_dsp_out;
  logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_size_dsp_out;
  logic                           fdt_blocked;
  logic                           err_valid;
  logic [REQ_ID_WIDTH-1:0]        err_id;
  logic [7:0]                     retry_count;
  dsp_state_t                     dbg_state;

  modport slave (
    input  req_valid, req_id, req_size, fdt_blocked,
    output req_ready, alloc_valid_dsp_out, alloc_id_dsp_out, alloc_size_dsp_out,
           err_valid, err_id, retry_count, dbg_state
  );

  modport master (
    output req_valid, req_id, req_size, fdt_blocked,
    input  req_ready, alloc_valid_dsp_out, alloc_id_dsp_out, alloc_size_dsp_out,
           err_valid, err_id, retry_count, dbg_state
  );
endinterface

// File: rtl/alloc_dispatcher_req_fifo.sv
// Synchronous request queue. Besides the usual flags it exposes the entry
// that will sit at the head after this cycle's push/pop, so the dispatcher
// can register its issue outputs in the same cycle it pops.
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_next,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW-1:0]    w_rd_ptr_p1;

  assign o_full      = (r_count == (AW+1)'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign w_do_push   = i_push & ~o_full;
  assign w_do_pop    = i_pop & ~o_empty;
  assign w_rd_ptr_p1 = r_rd_ptr + AW'(1);

  // Storage write; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= w_rd_ptr_p1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head as seen next cycle: skip past a popped entry, or forward a push into an empty slot.
  always_comb begin
    o_head_next = r_mem[r_rd_ptr];
    if (i_pop) begin
      if (r_count > (AW+1)'(1)) o_head_next = r_mem[w_rd_ptr_p1];
      else                      o_head_next = i_wr_data;
    end else if (r_count == '0) begin
      o_head_next = i_wr_data;
    end
  end
endmodule

// File: rtl/alloc_dispatcher.sv
// Allocation front-end: classifies and queues requests, issues the queue
// head to find_table one at a time, and replays it after a fixed backoff
// whenever find_table reports the class as blocked.
module alloc_dispatcher
  import alloc_dispatcher_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SIZE_WIDTH = 13,
  parameter int RETRY_GAP  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alloc_dispatcher_if.slave bus
);
  localparam int CNT_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = REQ_ID_WIDTH + REQ_SIZE_TYPE_WIDTH;

  logic [SIZE_WIDTH-1:0]          w_req_size;
  logic [31:0]                    w_req_bytes;
  logic                           w_size_ok;
  logic                           w_hs;
  logic                           w_push;
  logic                           w_bad;
  logic [ENT_W-1:0]               w_entry;
  logic [ENT_W-1:0]               w_head_next;
  logic                           w_full;
  logic                           w_empty;
  logic [OCC_W-1:0]               w_count;
  logic                           w_pop;
  logic                           w_load_bo;
  logic                           w_retry_inc;
  dsp_state_t                     r_state;
  dsp_state_t                     w_next_state;
  logic [CNT_W-1:0]               r_bo_cnt;
  logic                           r_alloc_valid;
  logic [REQ_ID_WIDTH-1:0]        r_alloc_id;
  logic [REQ_SIZE_TYPE_WIDTH-1:0] r_alloc_size;
  logic                           r_err_valid;
  logic [REQ_ID_WIDTH-1:0]        r_err_id;
  logic [7:0]                     r_retry_cnt;

  assign w_req_size  = bus.req_size;
  assign w_req_bytes = 32'(w_req_size);
  assign w_size_ok   = size_is_legal(w_req_bytes);
  assign w_hs        = bus.req_valid & bus.req_ready;
  assign w_push      = w_hs & w_size_ok;
  assign w_bad       = w_hs & ~w_size_ok;
  assign w_entry     = {bus.req_id, size_to_class(w_req_bytes)};

  req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_req_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_wr_data   (w_entry),
    .i_pop       (w_pop),
    .o_head_next (w_head_next),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= DSP_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; fdt_blocked only matters in CHECK, where it answers the previous issue.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_load_bo    = 1'b0;
    w_retry_inc  = 1'b0;
    case (r_state)
      DSP_IDLE: begin
        if (!w_empty) w_next_state = DSP_ISSUE;
      end
      DSP_ISSUE: begin
        w_next_state = DSP_CHECK;
      end
      DSP_CHECK: begin
        if (bus.fdt_blocked) begin
          w_load_bo    = 1'b1;
          w_next_state = DSP_BACKOFF;
        end else begin
          w_pop = 1'b1;
          if ((w_count > OCC_W'(1)) || w_push) w_next_state = DSP_ISSUE;
          else                                 w_next_state = DSP_IDLE;
        end
      end
      DSP_BACKOFF: begin
        if (r_bo_cnt == '0) begin
          w_retry_inc  = 1'b1;
          w_next_state = DSP_ISSUE;
        end
      end
      default: w_next_state = DSP_IDLE;
    endcase
  end

  // Backoff countdown: loaded on a blocked CHECK, runs RETRY_GAP cycles in BACKOFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_bo_cnt <= '0;
    else if (w_load_bo)                              r_bo_cnt <= CNT_W'(RETRY_GAP - 1);
    else if (r_state == DSP_BACKOFF && r_bo_cnt != '0) r_bo_cnt <= r_bo_cnt - CNT_W'(1);
  end

  // Issue outputs registered on entry to ISSUE; id/class hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc_valid <= 1'b0;
      r_alloc_id    <= '0;
      r_alloc_size  <= '0;
    end else if (w_next_state == DSP_ISSUE) begin
      r_alloc_valid <= 1'b1;
      r_alloc_id    <= w_head_next[ENT_W-1:REQ_SIZE_TYPE_WIDTH];
      r_alloc_size  <= w_head_next[REQ_SIZE_TYPE_WIDTH-1:0];
    end else begin
      r_alloc_valid <= 1'b0;
    end
  end

  // Rejected requests report one cycle after their handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_valid <= 1'b0;
      r_err_id    <= '0;
    end else begin
      r_err_valid <= w_bad;
      if (w_bad) r_err_id <= bus.req_id;
    end
  end

  // Saturating count of re-issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_retry_cnt <= '0;
    else if (w_retry_inc && r_retry_cnt != 8'hFF) r_retry_cnt <= r_retry_cnt + 8'd1;
  end

  assign bus.req_ready           = ~w_full;
  assign bus.alloc_valid_dsp_out = r_alloc_valid;
  assign bus.alloc_id_dsp_out    = r_alloc_id;
  assign bus.alloc_size_dsp_out  = r_alloc_size;
  assign bus.err_valid           = r_err_valid;
  assign bus.err_id              = r_err_id;
  assign bus.retry_count         = r_retry_cnt;
  assign bus.dbg_state           = r_state;
endmodule

// File: tb/tb_alloc_dispatcher.sv
// Bench for alloc_dispatcher: scoreboard of expected issues and errors,
// driver task for requests, fdt_blocked driven as a level per phase.
module tb_alloc_dispatcher;
  import alloc_dispatcher_pkg::*;

  localparam int SW    = 13;
  localparam int ENT_W = REQ_ID_WIDTH + REQ_SIZE_TYPE_WIDTH;
  localparam int GAP   = 8;

  logic clk;
  logic rst_n;

  alloc_dispatcher_if #(.SIZE_WIDTH(SW)) ifc ();

  alloc_dispatcher #(
    .FIFO_DEPTH (4),
    .SIZE_WIDTH (SW),
    .RETRY_GAP  (GAP)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [ENT_W-1:0]        exp_q[$];
  logic [REQ_ID_WIDTH-1:0] err_q[$];
  int issue_cyc[$];
  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int issue_cnt = 0;
  int last_push_cyc = 0;
  int last_err_cyc  = 0;
  bit pending = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [REQ_SIZE_TYPE_WIDTH-1:0] exp_class(input int sz);
    int n;
    n = (sz + 511) / 512;
    if (n == 1)      return 2'd0;
    else if (n == 2) return 2'd1;
    else if (n <= 4) return 2'd2;
    else             return 2'd3;
  endfunction

  // Monitor on the falling edge: resolve the previous CHECK, then compare outputs.
  always @(negedge clk) begin
    logic [ENT_W-1:0] ent;
    cyc = cyc + 1;
    if (pending) begin
      pending = 1'b0;
      if (!ifc.fdt_blocked && exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (ifc.alloc_valid_dsp_out) begin
      issue_cnt++;
      issue_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk_eq("spurious_issue", 32'(ifc.alloc_valid_dsp_out), 32'd0);
      end else begin
        ent = exp_q[0];
        chk_eq("issue_id", 32'(ifc.alloc_id_dsp_out), 32'(ent[ENT_W-1:REQ_SIZE_TYPE_WIDTH]));
        chk_eq("issue_class", 32'(ifc.alloc_size_dsp_out), 32'(ent[REQ_SIZE_TYPE_WIDTH-1:0]));
        pending = 1'b1;
      end
    end
    if (ifc.err_valid) begin
      last_err_cyc = cyc;
      if (err_q.size() == 0) chk_eq("spurious_err", 32'(ifc.err_valid), 32'd0);
      else                   chk_eq("err_id", 32'(ifc.err_id), 32'(err_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_req(input logic [REQ_ID_WIDTH-1:0] id, input int sz);
    int t;
    t = 0;
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.req_id    = id;
    ifc.req_size  = SW'(sz);
    while (!ifc.req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ifc.req_ready) begin
      chk_eq("push_timeout", 32'(ifc.req_ready), 32'd1);
      ifc.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_push_cyc = cyc;
    if (sz >= 1 && sz <= 4096) exp_q.push_back({id, exp_class(sz)});
    else                       err_q.push_back(id);
    ifc.req_valid = 1'b0;
  endtask

  task automatic wait_issues(input int n, input string tag);
    int t;
    t = 0;
    while (issue_cnt < n && t < 400) begin
      step();
      t++;
    end
    chk_eq(tag, 32'(issue_cnt), 32'(n));
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || ifc.dbg_state != DSP_IDLE) && t < 400) begin
      step();
      t++;
    end
    chk_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b;
    int t;
    int rel_cyc;
    rst_n           = 1'b0;
    ifc.req_valid   = 1'b0;
    ifc.req_id      = '0;
    ifc.req_size    = '0;
    ifc.fdt_blocked = 1'b0;
    repeat (3) step();
    chk_eq("rst_ready", 32'(ifc.req_ready), 32'd1);
    chk_eq("rst_alloc_valid", 32'(ifc.alloc_valid_dsp_out), 32'd0);
    chk_eq("rst_retry", 32'(ifc.retry_count), 32'd0);
    chk_eq("rst_state", 32'(ifc.dbg_state), 32'(DSP_IDLE));
    rst_n = 1'b1;
    repeat (2) step();

    // Reset while a blocked request sits in BACKOFF.
    ifc.fdt_blocked = 1'b1;
    push_req(8'd1, 100);
    t = 0;
    while (ifc.dbg_state != DSP_BACKOFF && t < 50) begin
      step();
      t++;
    end
    chk_eq("reach_backoff", 32'(ifc.dbg_state), 32'(DSP_BACKOFF));
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_ready", 32'(ifc.req_ready), 32'd1);
    chk_eq("mid_rst_valid", 32'(ifc.alloc_valid_dsp_out), 32'd0);
    chk_eq("mid_rst_id", 32'(ifc.alloc_id_dsp_out), 32'd0);
    chk_eq("mid_rst_size", 32'(ifc.alloc_size_dsp_out), 32'd0);
    chk_eq("mid_rst_err", 32'(ifc.err_valid), 32'd0);
    chk_eq("mid_rst_err_id", 32'(ifc.err_id), 32'd0);
    chk_eq("mid_rst_retry", 32'(ifc.retry_count), 32'd0);
    chk_eq("mid_rst_state", 32'(ifc.dbg_state), 32'(DSP_IDLE));
    exp_q.delete();
    pending = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    ifc.fdt_blocked = 1'b0;
    b = issue_cnt;
    repeat (15) step();
    chk_eq("no_issue_after_rst", 32'(issue_cnt), 32'(b));

    // Single request, latency from push cycle to issue.
    b = issue_cnt;
    push_req(8'd5, 700);
    wait_issues(b + 1, "t2_issue");
    chk_eq("t2_latency", 32'(issue_cyc[issue_cyc.size()-1] - last_push_cyc), 32'd2);
    chk_eq("t2_class", 32'(ifc.alloc_size_dsp_out), 32'(REQ_1K));
    repeat (4) step();

    // Class boundaries back-to-back.
    b = issue_cnt;
    push_req(8'd11, 1);
    rel_cyc = last_push_cyc;
    push_req(8'd12, 512);
    push_req(8'd13, 513);
    push_req(8'd14, 4096);
    wait_issues(b + 4, "t3_issues");
    chk_eq("t3_first_lat", 32'(issue_cyc[b] - rel_cyc), 32'd2);
    for (int i = 1; i < 4; i++)
      chk_eq("t3_gap", 32'(issue_cyc[b+i] - issue_cyc[b+i-1]), 32'd2);
    repeat (4) step();

    // Illegal sizes go to the error port, nothing issued.
    b = issue_cnt;
    push_req(8'd9, 0);
    push_req(8'd10, 5000);
    repeat (3) step();
    chk_eq("t4_err_lat", 32'(last_err_cyc - last_push_cyc), 32'd1);
    chk_eq("t4_no_issue", 32'(issue_cnt), 32'(b));
    chk_eq("t4_err_drained", 32'(err_q.size()), 32'd0);

    // Two blocked CHECKs then release; retries spaced by the backoff.
    ifc.fdt_blocked = 1'b1;
    b = issue_cnt;
    push_req(8'd3, 2048);
    push_req(8'd4, 100);
    wait_issues(b + 3, "t5_retries");
    ifc.fdt_blocked = 1'b0;
    wait_issues(b + 4, "t5_next");
    chk_eq("t5_gap1", 32'(issue_cyc[b+1] - issue_cyc[b]), 32'(GAP + 2));
    chk_eq("t5_gap2", 32'(issue_cyc[b+2] - issue_cyc[b+1]), 32'(GAP + 2));
    chk_eq("t5_gap3", 32'(issue_cyc[b+3] - issue_cyc[b+2]), 32'd2);
    chk_eq("t5_retry_cnt", 32'(ifc.retry_count), 32'd2);
    wait_drain("t5_drain");

    // Fill the queue behind a blocked head; fifth push waits for the first pop.
    ifc.fdt_blocked = 1'b1;
    push_req(8'd20, 100);
    push_req(8'd21, 1000);
    push_req(8'd22, 2000);
    push_req(8'd23, 3000);
    step();
    chk_eq("t6_full", 32'(ifc.req_ready), 32'd0);
    rel_cyc = 0;
    fork
      push_req(8'd24, 4096);
      begin
        repeat (6) step();
        chk_eq("t6_still_full", 32'(ifc.req_ready), 32'd0);
        rel_cyc = cyc;
        ifc.fdt_blocked = 1'b0;
      end
    join
    chk_eq("t6_push_after_pop", 32'(last_push_cyc > rel_cyc), 32'd1);
    wait_drain("t6_drain");

    // Long block: retry counter saturates.
    ifc.fdt_blocked = 1'b1;
    push_req(8'd30, 64);
    t = 0;
    while (ifc.retry_count != 8'd255 && t < 3000) begin
      step();
      t++;
    end
    chk_eq("t7_sat", 32'(ifc.retry_count), 32'd255);
    repeat (25) step();
    chk_eq("t7_sat_hold", 32'(ifc.retry_count), 32'd255);
    ifc.fdt_blocked = 1'b0;
    wait_drain("t7_drain");

    repeat (5) step();
    chk_eq("end_exp_q", 32'(exp_q.size()), 32'd0);
    chk_eq("end_err_q", 32'(err_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
